iagc_frame_logger: RTL and testbench
====================================

Name: iagc_frame_logger

Overview:
Periodic telemetry logger for the IAGC loop. It snapshots the reference amplitude, error amplitude, gain quotient/fraction and phase/watchdog flags. It serialises them as a fixed 7-byte frame on a UART TX line (8N1). It sits beside the IAGC controller and drives the board UART pin; a host or a uart_rx model decodes the frames.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock frequency in Hz.
UART_FREQUENCY, 9_200, baud rate; bit period BIT_CYCLES = CLK_FREQUENCY / UART_FREQUENCY (integer division; 10869 at defaults).
TICKS, 300000, idle clock cycles between the end of one frame and the start of the next.
AMPLITUDE_DATA_SIZE, 16, width of amplitude inputs (fixed at 16; frame format depends on it).
IAGC_STATUS_SIZE, 4, width of status input.

Ports:
i_clock  in  1  system clock, all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_iagcStatus  in  4  IAGC controller state; 4'b0000 = RESET state (logging disabled).
i_referenceAmplitude  in  16  reference amplitude.
i_errorAmplitude  in  16  error amplitude.
i_quotient  in  8  gain integer part.
i_fractional  in  8  gain fractional part.
i_onPhase  in  1  on-phase flag.
i_wdValid  in  1  watchdog-valid flag.
o_txBit  out  1  UART TX line, idle high.

Behaviour:
- Reset (i_reset=1 at a clock edge): state WAIT, tick counter 0, bit/byte counters 0, o_txBit=1 from the next cycle. A reset mid-frame aborts the frame immediately with no partial stop bit.
- Enable: logging is enabled when i_iagcStatus != 4'b0000.
  - While disabled, the tick counter is held at 0 and no frame starts.
  - A frame already in progress always completes.
- WAIT: tick counter increments each cycle while enabled. When it reaches TICKS-1: counter cleared, all inputs snapshotted into a 7-byte frame register in that same cycle, go to START.
  - The first frame therefore begins TICKS cycles after the status leaves RESET.
- Frame byte order:
  - B0=ref[7:0], B1=ref[15:8]
  - B2=err[7:0], B3=err[15:8]
  - B4=quotient, B5=fractional
  - B6={6'b0, wdValid, onPhase}
- Inputs changing mid-frame do not affect the frame being sent.
- Per byte: START (o_txBit=0, BIT_CYCLES cycles), then DATA (8 bits LSB first, BIT_CYCLES each), then STOP (o_txBit=1, BIT_CYCLES cycles).
- Bytes are back-to-back: after the STOP of B0..B5, the START of the next byte begins immediately.
- After the STOP of B6, return to WAIT with the counter at 0.
- Frame length is exactly 70*BIT_CYCLES cycles.
- o_txBit is registered (driven from a flop, no combinational path from inputs).
- States: WAIT, START, DATA, STOP.
  - Byte index wraps 6 -> 0 at frame end.
  - Bit index wraps 7 -> 0 at end of DATA.

Optional Feature:
Macro LOGGER_STATUS_BYTE_EN.
- Defined: B6 = {2'b0, iagcStatus[3:0], wdValid, onPhase}, with the status snapshotted with the other fields.
- Undefined (default): B6 upper 6 bits are zero, as above.
- Frame length and timing are identical in both cases.

Test Plan:
- Reset held, status 0 -> o_txBit stays 1, no start bit for >2*TICKS cycles.
- Status 0 -> 1 then 4'b1111 with ref=0x000F, err=0x00F0, quotient=0x50, fractional=0x05, onPhase=0, wdValid=1 -> uart_rx at 9200 baud decodes 0x0F,0x00,0xF0,0x00,0x50,0x05,0x02 in order; the sequence repeats each frame.
- Measure the falling edge of the B0 start bit -> exactly TICKS cycles after the status became nonzero; the next frame starts 70*BIT_CYCLES+TICKS cycles later.
- Change ref to 0x1234 during B1 of a frame -> that frame still carries 0x0F,0x00; the next frame carries 0x34,0x12.
- Assert i_reset during B3 -> o_txBit=1 next cycle and held; after release and with status nonzero, a full correct frame follows TICKS cycles later.
- With LOGGER_STATUS_BYTE_EN, status=4'b1111, wdValid=1, onPhase=1 -> B6=0x3F.

Source files
------------

// File: rtl/iagc_frame_logger.sv
`default_nettype none
// ============================================================================
// Module      : iagc_frame_logger
// Description : Periodic IAGC telemetry logger; snapshots loop state and
//               sends it as a 7-byte 8N1 UART frame. Optional macro
//               LOGGER_STATUS_BYTE_EN puts the IAGC status into byte 6.
// Revision    : 1.0 - initial release
// ============================================================================
module iagc_frame_logger #(
    parameter int CLK_FREQUENCY       = 100_000_000,
    parameter int UART_FREQUENCY      = 9_200,
    parameter int TICKS               = 300000,
    parameter int AMPLITUDE_DATA_SIZE = 16,
    parameter int IAGC_STATUS_SIZE    = 4
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [IAGC_STATUS_SIZE-1:0]    i_iagcStatus,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_referenceAmplitude,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_errorAmplitude,
    input  logic [7:0]                     i_quotient,
    input  logic [7:0]                     i_fractional,
    input  logic                           i_onPhase,
    input  logic                           i_wdValid,
    output logic                           o_txBit
);

    localparam int C_BIT_CYCLES = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int C_CYC_W      = (C_BIT_CYCLES > 1) ? $clog2(C_BIT_CYCLES) : 1;
    localparam int C_TICK_W     = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [C_CYC_W-1:0]  C_CYC_LAST  = C_CYC_W'(C_BIT_CYCLES - 1);
    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICKS - 1);
    localparam logic [2:0]          C_LAST_BYTE = 3'd6;
    localparam logic [2:0]          C_LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_TICK_W-1:0]   r_tick;
    logic [C_TICK_W-1:0]   w_tick_nxt;
    logic [C_CYC_W-1:0]    r_cyc;
    logic [C_CYC_W-1:0]    w_cyc_nxt;
    logic [2:0]            r_bit;
    logic [2:0]            w_bit_nxt;
    logic [2:0]            r_byte;
    logic [2:0]            w_byte_nxt;
    logic [55:0]           r_frame;
    logic [55:0]           w_snapshot;
    logic [7:0]            w_flags_byte;
    logic                  w_load;
    logic                  w_tx_nxt;
    logic                  w_enable;
    logic                  w_cyc_done;

`ifdef LOGGER_STATUS_BYTE_EN
    assign w_flags_byte = {2'b00, i_iagcStatus[3:0], i_wdValid, i_onPhase};
`else
    assign w_flags_byte = {6'b000000, i_wdValid, i_onPhase};
`endif

    // Byte n of the frame lives at r_frame[8n+7:8n]; {byte,bit} indexes it directly.
    assign w_snapshot = {w_flags_byte, i_fractional, i_quotient,
                         i_errorAmplitude[15:0], i_referenceAmplitude[15:0]};

    assign w_enable   = (i_iagcStatus != '0);
    assign w_cyc_done = (r_cyc == C_CYC_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_cyc_nxt   = r_cyc;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_load      = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            S_WAIT: begin
                if (!w_enable) begin
                    w_tick_nxt = '0;
                end else if (r_tick == C_TICK_LAST) begin
                    w_tick_nxt  = '0;
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_START: begin
                if (w_cyc_done) begin
                    w_cyc_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cyc_done) begin
                    w_cyc_nxt = '0;
                    if (r_bit == C_LAST_BIT) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            S_STOP: begin
                if (w_cyc_done) begin
                    w_cyc_nxt = '0;
                    if (r_byte == C_LAST_BYTE) begin
                        w_byte_nxt  = '0;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_byte_nxt  = r_byte + 1'b1;
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase

        // The line level is derived from the next state so it flips on the
        // same edge as the state, keeping the output a clean flop.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = r_frame[{w_byte_nxt, w_bit_nxt}];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_WAIT;
            r_tick  <= '0;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_frame <= '0;
            o_txBit <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_cyc   <= w_cyc_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            o_txBit <= w_tx_nxt;
            if (w_load) begin
                r_frame <= w_snapshot;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iagc_frame_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_iagc_frame_logger
// Description : Self-checking bench; a bit-sampling UART receiver decodes the
//               frames and compares them with a frame model built from inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iagc_frame_logger;

    localparam int CLK_FREQUENCY  = 1_000_000;
    localparam int UART_FREQUENCY = 100_000;
    localparam int TICKS          = 200;
    localparam int BC             = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int FRAME_CYC      = 70 * BC;
    localparam int LIMIT          = 2 * TICKS + FRAME_CYC;
`ifdef LOGGER_STATUS_BYTE_EN
    localparam logic [3:0] STATUS_MASK = 4'hF;
    localparam logic [7:0] B6_ALL_SET  = 8'h3F;
`else
    localparam logic [3:0] STATUS_MASK = 4'h0;
    localparam logic [7:0] B6_ALL_SET  = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  status;
    logic [15:0] ref_amp;
    logic [15:0] err_amp;
    logic [7:0]  quot;
    logic [7:0]  frac;
    logic        on_phase;
    logic        wd_valid;
    logic        tx;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iagc_frame_logger #(
        .CLK_FREQUENCY      (CLK_FREQUENCY),
        .UART_FREQUENCY     (UART_FREQUENCY),
        .TICKS              (TICKS),
        .AMPLITUDE_DATA_SIZE(16),
        .IAGC_STATUS_SIZE   (4)
    ) dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_iagcStatus        (status),
        .i_referenceAmplitude(ref_amp),
        .i_errorAmplitude    (err_amp),
        .i_quotient          (quot),
        .i_fractional        (frac),
        .i_onPhase           (on_phase),
        .i_wdValid           (wd_valid),
        .o_txBit             (tx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame as it should appear on the wire, byte 0 in the low bits.
    function automatic logic [55:0] model_frame();
        logic [7:0] b6;
        b6 = {2'b00, status & STATUS_MASK, wd_valid, on_phase};
        return {b6, frac, quot, err_amp, ref_amp};
    endfunction

    task automatic randomize_inputs();
        status   = 4'($urandom_range(1, 15));
        ref_amp  = 16'($urandom());
        err_amp  = 16'($urandom());
        quot     = 8'($urandom());
        frac     = 8'($urandom());
        on_phase = 1'($urandom());
        wd_valid = 1'($urandom());
    endtask

    task automatic wait_start(input int limit, output int start, output bit to);
        to    = 1'b1;
        start = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                start = cyc;
                to    = 1'b0;
                break;
            end
        end
    endtask

    // Samples the middle of each of the 70 bit slots of a frame.
    task automatic recv_frame(input int limit, output logic [55:0] d, output int start,
                              output bit to, output bit framing_ok);
        d          = '0;
        framing_ok = 1'b0;
        wait_start(limit, start, to);
        if (!to) begin
            framing_ok = 1'b1;
            for (int s = 0; s < 70; s++) begin
                int k;
                if (s == 0) repeat (BC / 2) @(negedge clk);
                else        repeat (BC) @(negedge clk);
                k = s % 10;
                if (k == 0)      framing_ok = framing_ok && (tx === 1'b0);
                else if (k == 9) framing_ok = framing_ok && (tx === 1'b1);
                else             d[(s / 10) * 8 + k - 1] = tx;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [55:0] d, input int start,
                               input bit to, input bit fr, input logic [55:0] exp_d,
                               input int exp_start);
        check({tag, "_timeout"}, 64'(to), 64'(0));
        check({tag, "_framing"}, 64'(fr), 64'(1));
        check({tag, "_data"}, 64'(d), 64'(exp_d));
        check({tag, "_start"}, 64'(start), 64'(exp_start));
    endtask

    initial begin
        logic [55:0] d;
        logic [55:0] exp_d;
        int          start;
        int          prev_start;
        int          t0;
        bit          to;
        bit          fr;
        bit          idle_ok;

        rst = 1'b1; status = 4'h0; ref_amp = '0; err_amp = '0;
        quot = '0; frac = '0; on_phase = 1'b0; wd_valid = 1'b0;

        idle_ok = 1'b1;
        repeat (2 * TICKS + 10) begin
            @(negedge clk);
            idle_ok = idle_ok && (tx === 1'b1);
        end
        check("reset_idle_high", 64'(idle_ok), 64'(1));

        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (2 * TICKS + 10) begin
            @(negedge clk);
            idle_ok = idle_ok && (tx === 1'b1);
        end
        check("disabled_idle_high", 64'(idle_ok), 64'(1));

        // Directed frame: status 0 -> 1 -> F, first start TICKS cycles later.
        ref_amp = 16'h000F; err_amp = 16'h00F0; quot = 8'h50; frac = 8'h05;
        on_phase = 1'b0; wd_valid = 1'b1;
        status = 4'h1;
        t0 = cyc;
        repeat (20) @(negedge clk);
        status = 4'hF;
        exp_d = model_frame();
        recv_frame(LIMIT, d, start, to, fr);
        check_frame("first", d, start, to, fr, exp_d, t0 + TICKS);
        check("first_b0_b5", 64'(d[47:0]), 64'(48'h05_50_00_F0_00_0F));
        prev_start = start;

        // Reference changes during B1; this frame keeps the old value.
        exp_d = model_frame();
        fork
            recv_frame(LIMIT, d, start, to, fr);
            begin : b_change_ref
                int s2;
                bit t2;
                wait_start(LIMIT, s2, t2);
                repeat (15 * BC) @(negedge clk);
                ref_amp = 16'h1234;
            end
        join
        check_frame("ref_change", d, start, to, fr, exp_d, prev_start + FRAME_CYC + TICKS);
        prev_start = start;

        exp_d = model_frame();
        recv_frame(LIMIT, d, start, to, fr);
        check_frame("ref_new", d, start, to, fr, exp_d, prev_start + FRAME_CYC + TICKS);
        check("ref_new_b0_b1", 64'(d[15:0]), 64'(16'h1234));
        prev_start = start;

        // Random frames with random mid-frame disturbances.
        randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            exp_d = model_frame();
            fork
                recv_frame(LIMIT, d, start, to, fr);
                begin : b_disturb
                    int s2;
                    bit t2;
                    wait_start(LIMIT, s2, t2);
                    repeat ($urandom_range(1, 69) * BC) @(negedge clk);
                    randomize_inputs();
                end
            join
            check_frame($sformatf("rand%0d", i), d, start, to, fr, exp_d,
                        prev_start + FRAME_CYC + TICKS);
            prev_start = start;
        end

        // Disabling mid-frame lets the frame finish, then nothing follows.
        exp_d = model_frame();
        fork
            recv_frame(LIMIT, d, start, to, fr);
            begin : b_disable
                int s2;
                bit t2;
                wait_start(LIMIT, s2, t2);
                repeat (20 * BC) @(negedge clk);
                status = 4'h0;
            end
        join
        check_frame("disable_mid", d, start, to, fr, exp_d, prev_start + FRAME_CYC + TICKS);
        wait_start(2 * TICKS, start, to);
        check("disabled_no_frame", 64'(to), 64'(1));

        // All flag bits set.
        randomize_inputs();
        status = 4'hF; on_phase = 1'b1; wd_valid = 1'b1;
        t0 = cyc;
        exp_d = model_frame();
        recv_frame(LIMIT, d, start, to, fr);
        check_frame("flags", d, start, to, fr, exp_d, t0 + TICKS);
        check("flags_b6", 64'(d[55:48]), 64'(B6_ALL_SET));
        prev_start = start;

        // Reset during the start bit of B3 aborts the frame at once.
        wait_start(LIMIT, start, to);
        check("pre_reset_timeout", 64'(to), 64'(0));
        check("pre_reset_start", 64'(start), 64'(prev_start + FRAME_CYC + TICKS));
        repeat (30 * BC + 2) @(negedge clk);
        check("b3_start_low", 64'(tx), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("reset_abort_high", 64'(tx), 64'(1));
        idle_ok = 1'b1;
        repeat (30 * BC) begin
            @(negedge clk);
            idle_ok = idle_ok && (tx === 1'b1);
        end
        check("reset_hold_high", 64'(idle_ok), 64'(1));
        randomize_inputs();
        rst = 1'b0;
        t0 = cyc;
        exp_d = model_frame();
        recv_frame(LIMIT, d, start, to, fr);
        check_frame("post_reset", d, start, to, fr, exp_d, t0 + TICKS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
